// File: rtl/sliscp_perm_ctrl.sv
// Purpose : iterative sLiSCP-light-192 controller; owns the state register, sequences STEPS steps.
// Latency : load accepted at cycle 0, out_valid at cycle STEPS*R+1 with R-cycle steps (145 for R=8).
// Backpres: out_state held in DONE until out_ready; in_ready only in IDLE, one cycle after out_ready.
//
// Ports:
//   clk, rst                    rising-edge clock, synchronous active-high reset
//   in_valid/in_ready/in_state  load request; state {s0,s1,s2,s3}, s0 in MSBs
//   out_valid/out_ready/out_state  permuted state handshake (out_state is the state register)
//   busy                        high while steps are running
//   step_sin/step_sout          state to / from the single-step datapath
//   step_en/step_done           datapath round-counter enable / end-of-step strobe
//   rc0,rc1,sc0,sc1             round and step constants for the current step index
module sliscp_perm_ctrl #(
    parameter int WIDTH        = 48,
    parameter int STEPS        = 18,
    parameter int G_ASYNC_RSTN = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [4*WIDTH-1:0]   in_state,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [4*WIDTH-1:0]   out_state,
    output logic                 busy,
    output logic [4*WIDTH-1:0]   step_sin,
    input  logic [4*WIDTH-1:0]   step_sout,
    output logic                 step_en,
    input  logic                 step_done,
    output logic [7:0]           rc0,
    output logic [7:0]           rc1,
    output logic [7:0]           sc0,
    output logic [7:0]           sc1
);

    localparam int CW = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [CW-1:0] LAST_STEP = CW'(STEPS - 1);

    // The constant ROM holds 18 entries; the async-reset flag only matters to the
    // step datapath, which sits outside this block.
    if (STEPS < 1 || STEPS > 18 || (G_ASYNC_RSTN != 0 && G_ASYNC_RSTN != 1)) begin : g_bad_param
        $error("sliscp_perm_ctrl: unsupported parameter set");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fsm_t;

    fsm_t                fsm_q, fsm_d;
    logic [4*WIDTH-1:0]  st_q, st_d;
    logic [CW-1:0]       ctr_q, ctr_d;
    logic [CW-1:0]       rom_idx;
    logic [31:0]         rom_word;

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q <= IDLE;
            st_q  <= '0;
            ctr_q <= '0;
        end else begin
            fsm_q <= fsm_d;
            st_q  <= st_d;
            ctr_q <= ctr_d;
        end
    end

    always_comb begin
        fsm_d = fsm_q;
        st_d  = st_q;
        ctr_d = ctr_q;
        unique case (fsm_q)
            IDLE: begin
                if (in_valid) begin
                    st_d  = in_state;
                    ctr_d = '0;
                    fsm_d = RUN;
                end
            end
            RUN: begin
                // Only RUN consumes step_done; a strobe in IDLE/DONE never touches st.
                if (step_done) begin
                    st_d = step_sout;
                    if (ctr_q == LAST_STEP) begin
                        fsm_d = DONE;
                    end else begin
                        ctr_d = ctr_q + 1'b1;
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    fsm_d = IDLE;
                end
            end
            default: fsm_d = IDLE;
        endcase
    end

    // All handshake outputs decode the registered state only, so there is no
    // combinational path from in_valid or out_ready to any output.
    assign in_ready  = (fsm_q == IDLE);
    assign out_valid = (fsm_q == DONE);
    assign busy      = (fsm_q == RUN);
    assign step_en   = (fsm_q == RUN);
    assign step_sin  = st_q;
    assign out_state = st_q;

    // ctr parks at the last index in DONE; force entry 0 outside RUN.
    assign rom_idx = (fsm_q == RUN) ? ctr_q : '0;

    // Entry = {rc0, rc1, sc0, sc1} for the step index.
    always_comb begin
        rom_word = '0;
        case (int'(rom_idx))
            0:       rom_word = 32'h07_27_08_29;
            1:       rom_word = 32'h04_34_0c_1d;
            2:       rom_word = 32'h06_2e_0a_33;
            3:       rom_word = 32'h25_19_2f_2a;
            4:       rom_word = 32'h17_35_38_1f;
            5:       rom_word = 32'h1c_0f_24_10;
            6:       rom_word = 32'h12_08_36_18;
            7:       rom_word = 32'h3b_0c_0d_14;
            8:       rom_word = 32'h26_0a_2b_1e;
            9:       rom_word = 32'h15_2f_3e_31;
            10:      rom_word = 32'h3f_38_01_09;
            11:      rom_word = 32'h20_24_21_2d;
            12:      rom_word = 32'h30_36_11_1b;
            13:      rom_word = 32'h28_0d_39_16;
            14:      rom_word = 32'h3c_2b_05_3d;
            15:      rom_word = 32'h22_3e_27_03;
            16:      rom_word = 32'h13_01_34_02;
            17:      rom_word = 32'h1a_21_2e_23;
            default: rom_word = '0;
        endcase
    end

    assign rc0 = rom_word[31:24];
    assign rc1 = rom_word[23:16];
    assign sc0 = rom_word[15:8];
    assign sc1 = rom_word[7:0];

endmodule

// File: tb/tb_sliscp_perm_ctrl.sv
// Purpose : scoreboard bench for sliscp_perm_ctrl with a behavioural sLiSCP-light-192 step datapath.
// Latency : expects out_valid 145 cycles after accept and 147-cycle back-to-back spacing.
// Backpres: exercises out_ready low for 20 cycles with in_valid pulses that must be refused.
module tb_sliscp_perm_ctrl;

    localparam int W   = 48;
    localparam int N   = 18;
    localparam int R   = 8;
    localparam int SW  = 4 * W;
    localparam int LAT = N * R + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [SW-1:0] in_state;
    logic          out_valid;
    logic          out_ready;
    logic [SW-1:0] out_state;
    logic          busy;
    logic [SW-1:0] step_sin;
    logic [SW-1:0] step_sout;
    logic          step_en;
    logic          step_done;
    logic [7:0]    rc0, rc1, sc0, sc1;
    logic          force_done;

    always #5 clk = ~clk;

    sliscp_perm_ctrl #(.WIDTH(W), .STEPS(N), .G_ASYNC_RSTN(0)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_state  (in_state),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_state (out_state),
        .busy      (busy),
        .step_sin  (step_sin),
        .step_sout (step_sout),
        .step_en   (step_en),
        .step_done (step_done),
        .rc0       (rc0),
        .rc1       (rc1),
        .sc0       (sc0),
        .sc1       (sc1)
    );

    // sLiSCP-light-192 constant table, {rc0, rc1, sc0, sc1} per step.
    logic [31:0] tbl [0:N-1] = '{
        32'h07270829, 32'h04340c1d, 32'h062e0a33, 32'h25192f2a, 32'h1735381f, 32'h1c0f2410,
        32'h12083618, 32'h3b0c0d14, 32'h260a2b1e, 32'h152f3e31, 32'h3f380109, 32'h2024212d,
        32'h3036111b, 32'h280d3916, 32'h3c2b053d, 32'h223e2703, 32'h13013402, 32'h1a212e23
    };

    // Simeck-48 box: six rounds, one constant bit per round.
    function automatic logic [47:0] ssb(input logic [47:0] v, input logic [7:0] rc);
        logic [23:0] x, y;
        logic [7:0]  r;
        x = v[47:24];
        y = v[23:0];
        r = rc;
        for (int i = 0; i < 3; i++) begin
            y = y ^ ({x[18:0], x[23:19]} & x) ^ {x[22:0], x[23]} ^ {23'h7FFFFF, r[0]};
            r = r >> 1;
            x = x ^ ({y[18:0], y[23:19]} & y) ^ {y[22:0], y[23]} ^ {23'h7FFFFF, r[0]};
            r = r >> 1;
        end
        return {x, y};
    endfunction

    function automatic logic [SW-1:0] step_f(input logic [SW-1:0] s, input logic [31:0] c);
        logic [47:0] b1, b3, a0, a2;
        b1 = ssb(s[143:96], c[31:24]);
        b3 = ssb(s[47:0], c[23:16]);
        a0 = s[191:144] ^ {40'hFFFFFFFFFF, c[15:8]};
        a2 = s[95:48] ^ {40'hFFFFFFFFFF, c[7:0]};
        return {b1, a2 ^ b3, b3, a0 ^ b1};
    endfunction

    function automatic logic [SW-1:0] perm_ref(input logic [SW-1:0] s);
        logic [SW-1:0] t;
        t = s;
        for (int i = 0; i < N; i++) t = step_f(t, tbl[i]);
        return t;
    endfunction

    // Step datapath model: registered enable, R-cycle rounds, wraps after step_done.
    logic       en_q = 1'b0;
    logic [2:0] rnd_q = 3'd0;
    always @(posedge clk) begin
        en_q  <= step_en;
        rnd_q <= en_q ? ((rnd_q == 3'(R - 1)) ? 3'd0 : rnd_q + 3'd1) : 3'd0;
    end
    assign step_done = (en_q && rnd_q == 3'(R - 1)) || force_done;
    assign step_sout = step_f(step_sin, {rc0, rc1, sc0, sc1});

    typedef struct {
        logic [SW-1:0] st;
        int            acc;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   k     = 0;
    logic chk_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [SW-1:0] got, input logic [SW-1:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", nm, got, want);
        end
    endtask

    // Monitor: constants, output hold, scoreboard pop on handshake.
    logic          prev_vld = 1'b0;
    logic [SW-1:0] held = '0;
    int            rise = 0;
    always @(negedge clk) begin
        exp_t e;
        if (chk_en) begin
            if (busy && k >= N) chk("step_index", k, N - 1);
            chk("const_rom", {rc0, rc1, sc0, sc1}, (busy && k < N) ? tbl[k] : tbl[0]);
            if (out_valid && prev_vld) chk("out_hold", out_state, held);
            if (out_valid && !prev_vld) rise = cyc;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_out: got out_valid=1 expected no result");
                end else begin
                    e = exp_q.pop_front();
                    chk("result", out_state, e.st);
                    chk("latency", rise - e.acc, LAT);
                end
            end
        end
        prev_vld = out_valid && !out_ready;
        held     = out_state;
        if (rst)                        k = 0;
        else if (in_valid && in_ready)  k = 0;
        else if (busy && step_done)     k = k + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [SW-1:0] st);
        in_state = st;
        in_valid = 1'b1;
        for (int i = 0; i < 400 && !in_ready; i++) tick();
        chk("load_accept", in_ready, 1);
        if (in_ready) exp_q.push_back('{st: perm_ref(st), acc: cyc + 1});
        tick();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 600 && exp_q.size() != 0; i++) tick();
        chk("drain", exp_q.size(), 0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_in_ready"},  in_ready,  1);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_busy"},      busy,      0);
        chk({tag, "_step_en"},   step_en,   0);
        chk({tag, "_out_state"}, out_state, 0);
    endtask

    initial begin
        logic [SW-1:0] pat;
        int a1, a2;
        rst        = 1'b1;
        in_valid   = 1'b0;
        in_state   = '0;
        out_ready  = 1'b0;
        force_done = 1'b0;

        // Reset for two cycles.
        tick();
        tick();
        rst = 1'b0;
        chk_reset_outputs("reset");
        chk_en = 1'b1;

        // step_done outside RUN must not write the state.
        force_done = 1'b1;
        tick();
        force_done = 1'b0;
        chk("idle_done_ignored", out_state, 0);
        chk("idle_in_ready", in_ready, 1);

        // KAT: all-zero state.
        out_ready = 1'b1;
        load('0);
        drain();

        // KAT: repeating 0123..EF.
        load({3{64'h0123456789ABCDEF}});
        drain();

        // Backpressure with refused loads and a stray step_done in DONE.
        out_ready = 1'b0;
        load({6{32'hA5C3_0F96}});
        for (int i = 0; i < 400 && !out_valid; i++) tick();
        chk("bp_out_valid_seen", out_valid, 1);
        for (int j = 0; j < 20; j++) begin
            in_valid   = j[0];
            in_state   = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
            force_done = (j == 5);
            tick();
            chk("bp_in_ready", in_ready, 0);
            chk("bp_out_valid", out_valid, 1);
        end
        in_valid   = 1'b0;
        force_done = 1'b0;
        out_ready  = 1'b1;
        tick();
        chk("bp_release_in_ready", in_ready, 1);
        drain();

        // Reset mid-run at step 7, round 3, coinciding with a step_done strobe.
        pat = {4{48'hDEADBEEF1234}};
        load(pat);
        for (int i = 0; i < 300 && !(k == 7 && rnd_q == 3'd3); i++) tick();
        chk("midrun_reached", (k == 7 && rnd_q == 3'd3) ? 1 : 0, 1);
        rst        = 1'b1;
        force_done = 1'b1;
        void'(exp_q.pop_back());
        tick();
        rst        = 1'b0;
        force_done = 1'b0;
        chk_reset_outputs("midrun_rst");
        for (int i = 0; i < 5; i++) tick();
        load(pat);
        drain();

        // Back-to-back with in_valid and out_ready held high.
        a1 = -1;
        a2 = -1;
        in_state = {3{64'hFEDCBA9876543210}};
        in_valid = 1'b1;
        for (int i = 0; i < 500 && a2 < 0; i++) begin
            if (in_ready) begin
                if (a1 < 0) a1 = cyc + 1;
                else        a2 = cyc + 1;
                exp_q.push_back('{st: perm_ref(in_state), acc: cyc + 1});
            end
            tick();
            if (a1 >= 0 && a2 < 0) in_state = {6{32'h1357_9BDF}};
        end
        in_valid = 1'b0;
        chk("b2b_spacing", a2 - a1, LAT + 2);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got no completion expected finish before timeout");
        $fatal(1);
    end

endmodule
